// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain clock/data pads.
// Optional feature macro PS2_TX_RETRY_EN: resend the latched byte up to twice before reporting a failure.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_TIMEOUT  = 375000,
    parameter int BIT_TIMEOUT    = 50000,
    parameter int FILT_LEN       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int TMO_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int INH_W   = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TMO_W   = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
    localparam int FLT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    localparam logic [INH_W-1:0] INH_LOAD   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] START_LOAD = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] BIT_LOAD   = TMO_W'(BIT_TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FILT_LEN - 1);
    localparam logic             INH_ONE    = (INHIBIT_CYCLES == 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic             r_clk_filt, r_clk_filt_d;
    logic [FLT_W-1:0] r_flt_cnt;
    logic [9:0]       r_frame, r_shift;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tx_ready, r_busy, r_done, r_ack_err, r_timeout;
    logic             r_clk_oe, r_dat_oe;

    logic w_clk_fall, w_lines_idle, w_ack_fail, w_tmo_fail, w_fail, w_retry, w_accept;

    assign tx_ready   = r_tx_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ack_err    = r_ack_err;
    assign timeout    = r_timeout;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

    // Only the clock needs deglitching; data is sampled on filtered clock events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_meta   <= 1'b1;
            r_clk_sync   <= 1'b1;
            r_dat_meta   <= 1'b1;
            r_dat_sync   <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_flt_cnt    <= '0;
        end else begin
            r_clk_meta   <= ps2_clk_in;
            r_clk_sync   <= r_clk_meta;
            r_dat_meta   <= ps2_dat_in;
            r_dat_sync   <= r_dat_meta;
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_LAST) begin
                r_clk_filt <= r_clk_sync;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_clk_fall   = r_clk_filt_d & ~r_clk_filt;
        w_lines_idle = r_clk_filt & r_dat_sync;
        w_ack_fail   = (r_state == ST_ACK) && w_clk_fall && r_dat_sync;
        w_tmo_fail   = 1'b0;
        if (r_tmo_cnt == '0) begin
            case (r_state)
                ST_REQ, ST_SHIFT, ST_ACK: w_tmo_fail = ~w_clk_fall;
                ST_WAIT_IDLE:             w_tmo_fail = ~w_lines_idle;
                default:                  w_tmo_fail = 1'b0;
            endcase
        end
        w_fail = w_ack_fail | w_tmo_fail;
    end

    assign w_accept = (r_state == ST_IDLE) && tx_valid && r_tx_ready;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] r_attempt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_attempt <= '0;
        end else if (w_accept) begin
            r_attempt <= '0;
        end else if (w_fail && w_retry) begin
            r_attempt <= r_attempt + 1'b1;
        end
    end

    assign w_retry = (r_attempt != 2'd2);
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
            if (r_tmo_cnt != '0) r_tmo_cnt <= r_tmo_cnt - 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (w_accept) begin
                        r_frame    <= {1'b1, ~^tx_data, tx_data};
                        r_shift    <= {1'b1, ~^tx_data, tx_data};
                        r_state    <= ST_INHIBIT;
                        r_clk_oe   <= 1'b1;
                        r_dat_oe   <= INH_ONE;
                        r_inh_cnt  <= INH_LOAD;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    if (r_inh_cnt == '0) begin
                        r_state   <= ST_REQ;
                        r_clk_oe  <= 1'b0;
                        r_dat_oe  <= 1'b1;
                        r_tmo_cnt <= START_LOAD;
                    end else begin
                        r_inh_cnt <= r_inh_cnt - 1'b1;
                        if (r_inh_cnt == INH_W'(1)) r_dat_oe <= 1'b1;
                    end
                end
                ST_REQ, ST_SHIFT: begin
                    if (w_clk_fall) begin
                        r_dat_oe  <= ~r_shift[0];
                        r_shift   <= {1'b0, r_shift[9:1]};
                        r_tmo_cnt <= BIT_LOAD;
                        if (r_state == ST_REQ) begin
                            r_bit_cnt <= 4'd1;
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 4'd9) r_state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (w_clk_fall && !r_dat_sync) begin
                        r_state   <= ST_WAIT_IDLE;
                        r_tmo_cnt <= BIT_LOAD;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_lines_idle) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Failure exits override whatever the state branch scheduled.
            if (w_fail) begin
                if (w_retry) begin
                    r_state   <= ST_INHIBIT;
                    r_shift   <= r_frame;
                    r_clk_oe  <= 1'b1;
                    r_dat_oe  <= INH_ONE;
                    r_inh_cnt <= INH_LOAD;
                end else begin
                    r_state   <= ST_IDLE;
                    r_clk_oe  <= 1'b0;
                    r_dat_oe  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ack_err <= w_ack_fail;
                    r_timeout <= w_tmo_fail;
                end
            end
        end
    end

endmodule
